// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared 32-bit ALU: round-robin grant on ties,
// one operation in flight, registered result held until the owner consumes it.
//
//  state | meaning
//  IDLE  | waiting for a request; grant is combinational, accept latches operands
//  EXEC  | latched op/operands drive the ALU for one cycle; result captured at exit
//  RESP  | result presented to the granted requester until it takes it
module alu_arbiter #(
  parameter int FIRST_GRANT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0Valid,
  input  logic        req1Valid,
  input  logic [3:0]  req0Op,
  input  logic [3:0]  req1Op,
  input  logic [31:0] req0Left,
  input  logic [31:0] req0Right,
  input  logic [31:0] req1Left,
  input  logic [31:0] req1Right,
  output logic        req0Ready,
  output logic        req1Ready,
  output logic        resp0Valid,
  output logic        resp1Valid,
  input  logic        resp0Ready,
  input  logic        resp1Ready,
  output logic [31:0] respResult,
  output logic        respZero,
  output logic [3:0]  aluOp,
  output logic [31:0] aluLeft,
  output logic [31:0] aluRight,
  input  logic [31:0] aluResult,
  input  logic        aluZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PTR_INIT = (FIRST_GRANT != 0);

  state_t state;
  state_t stateNext;
  logic   rrPtr;
  logic   grantId;
  logic   grant0;
  logic   grant1;
  logic   accept;
  logic   done;

  // A lone requester always wins; the pointer only breaks ties.
  assign grant0 = req0Valid && (!req1Valid || !rrPtr);
  assign grant1 = req1Valid && (!req0Valid || rrPtr);
  assign accept = (state == IDLE) && (grant0 || grant1);

  always_comb begin
    stateNext  = state;
    req0Ready  = 1'b0;
    req1Ready  = 1'b0;
    resp0Valid = 1'b0;
    resp1Valid = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // Gate with rst so no handshake is advertised while reset is held.
        req0Ready = grant0 && !rst;
        req1Ready = grant1 && !rst;
        if (grant0 || grant1) stateNext = EXEC;
      end
      EXEC: stateNext = RESP;
      RESP: begin
        resp0Valid = !grantId;
        resp1Valid = grantId;
        if ((!grantId && resp0Ready) || (grantId && resp1Ready)) begin
          done      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rrPtr      <= PTR_INIT;
      grantId    <= 1'b0;
      aluOp      <= 4'd0;
      aluLeft    <= 32'd0;
      aluRight   <= 32'd0;
      respResult <= 32'd0;
      respZero   <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        grantId  <= grant1;
        aluOp    <= grant1 ? req1Op    : req0Op;
        aluLeft  <= grant1 ? req1Left  : req0Left;
        aluRight <= grant1 ? req1Right : req0Right;
      end
      if (state == EXEC) begin
        respResult <= aluResult;
        respZero   <= aluZero;
      end
      if (done) rrPtr <= !grantId;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the shared ALU is modelled here with a small
// reference encoding (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, others DEADBEEF).
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_BAD = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0Valid, req1Valid;
  logic [3:0]  req0Op, req1Op;
  logic [31:0] req0Left, req0Right, req1Left, req1Right;
  logic        req0Ready, req1Ready;
  logic        resp0Valid, resp1Valid;
  logic        resp0Ready, resp1Ready;
  logic [31:0] respResult;
  logic        respZero;
  logic [3:0]  aluOp;
  logic [31:0] aluLeft, aluRight;
  logic [31:0] aluResult;
  logic        aluZero;

  int total = 0;
  int bad = 0;

  alu_arbiter #(.FIRST_GRANT(0)) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Op(req0Op), .req1Op(req1Op),
    .req0Left(req0Left), .req0Right(req0Right),
    .req1Left(req1Left), .req1Right(req1Right),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .resp0Valid(resp0Valid), .resp1Valid(resp1Valid),
    .resp0Ready(resp0Ready), .resp1Ready(resp1Ready),
    .respResult(respResult), .respZero(respZero),
    .aluOp(aluOp), .aluLeft(aluLeft), .aluRight(aluRight),
    .aluResult(aluResult), .aluZero(aluZero)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (aluOp)
      4'd0:    aluResult = aluLeft + aluRight;
      4'd1:    aluResult = aluLeft - aluRight;
      4'd2:    aluResult = aluLeft & aluRight;
      4'd3:    aluResult = aluLeft | aluRight;
      4'd4:    aluResult = aluLeft ^ aluRight;
      4'd5:    aluResult = {31'd0, $signed(aluLeft) < $signed(aluRight)};
      default: aluResult = 32'hDEAD_BEEF;
    endcase
  end
  assign aluZero = (aluResult == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge, then let logic settle.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req0Valid = 1'b1; req1Valid = 1'b0;
    req0Op = OP_ADD; req1Op = OP_ADD;
    req0Left = 32'd0; req0Right = 32'd0; req1Left = 32'd0; req1Right = 32'd0;
    resp0Ready = 1'b0; resp1Ready = 1'b0;

    // Reset values while rst is held, even with a request pending
    nxt(); nxt(); #1;
    chk("rst_req0Ready", req0Ready, 0);
    chk("rst_resp0Valid", resp0Valid, 0);
    chk("rst_respResult", respResult, 0);
    chk("rst_respZero", respZero, 0);
    chk("rst_aluOp", aluOp, 0);
    chk("rst_aluLeft", aluLeft, 0);
    chk("rst_aluRight", aluRight, 0);

    // Contention from reset: req0 add 1+2, req1 sub 10-3
    req0Valid = 1'b1; req0Op = OP_ADD; req0Left = 32'd1;  req0Right = 32'd2;
    req1Valid = 1'b1; req1Op = OP_SUB; req1Left = 32'd10; req1Right = 32'd3;
    rst = 1'b0; #1;
    chk("tie0_req0Ready", req0Ready, 1);
    chk("tie0_req1Ready", req1Ready, 0);
    nxt();
    chk("tie0_exec_req0Ready", req0Ready, 0);
    chk("tie0_exec_req1Ready", req1Ready, 0);
    chk("tie0_exec_resp0Valid", resp0Valid, 0);
    chk("tie0_exec_aluOp", aluOp, OP_ADD);
    nxt();
    chk("tie0_resp0Valid", resp0Valid, 1);
    chk("tie0_resp1Valid", resp1Valid, 0);
    chk("tie0_respResult", respResult, 3);
    chk("tie0_resp_req1Ready", req1Ready, 0);
    resp0Ready = 1'b1;
    nxt();
    resp0Ready = 1'b0; #1;
    chk("tie1_req1Ready", req1Ready, 1);
    chk("tie1_req0Ready", req0Ready, 0);
    chk("tie1_resp0Valid", resp0Valid, 0);
    nxt(); nxt();
    chk("tie1_resp1Valid", resp1Valid, 1);
    chk("tie1_respResult", respResult, 7);
    chk("tie1_respZero", respZero, 0);

    // Back-pressure: resp1Ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("bp_resp1Valid", resp1Valid, 1);
      chk("bp_respResult", respResult, 7);
      chk("bp_req0Ready", req0Ready, 0);
      chk("bp_aluLeft", aluLeft, 10);
    end
    resp1Ready = 1'b1;
    nxt();
    resp1Ready = 1'b0; req1Valid = 1'b0; #1;
    chk("alt_req0Ready", req0Ready, 1);
    nxt(); nxt();
    chk("alt_resp0Valid", resp0Valid, 1);
    chk("alt_respResult", respResult, 3);

    // Wrong-side ready is ignored while requester 0 owns RESP
    resp1Ready = 1'b1;
    nxt();
    chk("wrong_resp0Valid", resp0Valid, 1);
    chk("wrong_req0Ready", req0Ready, 0);
    resp1Ready = 1'b0; resp0Ready = 1'b1; req0Valid = 1'b0;
    nxt();
    resp0Ready = 1'b0; #1;
    chk("idle_resp0Valid", resp0Valid, 0);
    chk("idle_hold_aluOp", aluOp, OP_ADD);
    chk("idle_hold_aluRight", aluRight, 2);

    // Zero/sub on req1: 9 - 9
    req1Valid = 1'b1; req1Op = OP_SUB; req1Left = 32'd9; req1Right = 32'd9; #1;
    chk("sub_req1Ready", req1Ready, 1);
    nxt();
    req1Valid = 1'b0;
    nxt();
    chk("sub_resp1Valid", resp1Valid, 1);
    chk("sub_respResult", respResult, 0);
    chk("sub_respZero", respZero, 1);
    resp1Ready = 1'b1;
    nxt();
    resp1Ready = 1'b0;

    // Lone req1 with pointer on req0: slt 3 vs 8
    req1Valid = 1'b1; req1Op = OP_SLT; req1Left = 32'd3; req1Right = 32'd8; #1;
    chk("slt_req1Ready", req1Ready, 1);
    nxt();
    req1Valid = 1'b0;
    nxt();
    chk("slt_respResult", respResult, 1);
    chk("slt_respZero", respZero, 0);
    resp1Ready = 1'b1;
    nxt();
    resp1Ready = 1'b0;

    // Undefined op code on lone req0 goes through to the ALU unchanged
    req0Valid = 1'b1; req0Op = OP_BAD; req0Left = 32'h55; req0Right = 32'hAA; #1;
    chk("bad_req0Ready", req0Ready, 1);
    nxt();
    req0Valid = 1'b0; #1;
    chk("bad_aluOp", aluOp, OP_BAD);
    nxt();
    chk("bad_respResult", respResult, 32'hDEAD_BEEF);
    resp0Ready = 1'b1;
    nxt();
    resp0Ready = 1'b0;

    // Pointer now favours req1: tie grants req1, then reset during EXEC
    req0Valid = 1'b1; req0Op = OP_ADD; req0Left = 32'd5; req0Right = 32'd7;
    req1Valid = 1'b1; req1Op = OP_ADD; req1Left = 32'd4; req1Right = 32'd4; #1;
    chk("tie2_req1Ready", req1Ready, 1);
    chk("tie2_req0Ready", req0Ready, 0);
    nxt();
    rst = 1'b1; #1;
    chk("abort_req0Ready", req0Ready, 0);
    chk("abort_req1Ready", req1Ready, 0);
    chk("abort_resp1Valid", resp1Valid, 0);
    chk("abort_respResult", respResult, 0);
    chk("abort_aluOp", aluOp, 0);
    chk("abort_aluLeft", aluLeft, 0);
    nxt();
    chk("abort_hold_resp1Valid", resp1Valid, 0);
    chk("abort_hold_resp0Valid", resp0Valid, 0);
    rst = 1'b0; #1;
    chk("post_rst_req0Ready", req0Ready, 1);
    chk("post_rst_req1Ready", req1Ready, 0);

    // Single op after reset: req0 add 5+7, response at cycle 2
    req1Valid = 1'b0;
    nxt();
    req0Valid = 1'b0;
    chk("single_c1_resp0Valid", resp0Valid, 0);
    nxt();
    chk("single_c2_resp0Valid", resp0Valid, 1);
    chk("single_respResult", respResult, 12);
    chk("single_respZero", respZero, 0);
    resp0Ready = 1'b1;
    nxt();
    resp0Ready = 1'b0; #1;
    chk("single_done_resp0Valid", resp0Valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
